// File: rtl/hit_det_pkg.sv
// Shared types, register map and reset defaults for the strike detector.
// Imported by hit_detector and hit_event_fifo users.
package hit_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        HOLDOFF
    } state_e;

    localparam logic [2:0] REG_THR_ON  = 3'd0;
    localparam logic [2:0] REG_THR_OFF = 3'd1;
    localparam logic [2:0] REG_HOLDOFF = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_EVENT   = 3'd4;
    localparam logic [2:0] REG_ENV     = 3'd5;

    localparam logic [23:0] THR_ON_DEFAULT  = 24'h100000;
    localparam logic [23:0] THR_OFF_DEFAULT = 24'h080000;
    localparam logic [15:0] HOLDOFF_DEFAULT = 16'd2400;

    localparam logic [23:0] ABS_MAX = 24'h7FFFFF;

    typedef struct packed {
        logic [15:0] ts;
        logic [15:0] peak;
    } hit_event_t;

    // Most-negative input has no positive counterpart, so it clips to ABS_MAX.
    function automatic logic [23:0] rectify(input logic [23:0] s);
        logic [23:0] r;
        if (s == 24'h800000) begin
            r = ABS_MAX;
        end else if (s[23]) begin
            r = -s;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/hit_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds only when a pop
// frees a slot in the same cycle.
module hit_event_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/hit_detector.sv
// Strike detector: rectify, leaky-integrator envelope, hysteresis/holdoff FSM,
// and an event FIFO drained over an Avalon-MM slave.
module hit_detector
    import hit_det_pkg::*;
#(
    parameter int unsigned ENV_SHIFT  = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [23:0] sample_in,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit_pulse
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [23:0]           env_q, env_d;
    logic [23:0]           peak_q, peak_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [TS_WIDTH-1:0]   pk_ts_q, pk_ts_d;
    logic [15:0]           hcnt_q, hcnt_d;
    logic [23:0]           abs_s;
    logic [23:0]           env_n;

    logic [23:0]           thr_on_q;
    logic [23:0]           thr_off_q;
    logic [15:0]           holdoff_q;
    logic                  overflow_q, overflow_d;
    logic [31:0]           readdata_q, rdata_d;
    logic                  hit_pulse_q;

    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic                  wr_en;
    hit_event_t            push_ev;
    logic [31:0]           fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [7:0]            unused_wdata;

    assign rd_en        = chipselect && read;
    assign wr_en        = chipselect && write;
    assign pop          = rd_en && (address == REG_EVENT) && !fifo_empty;
    assign unused_wdata = writedata[31:24];

    // env never exceeds ABS_MAX, so the subtract-then-add cannot wrap.
    assign abs_s = rectify(sample_in);
    assign env_n = env_q - (env_q >> ENV_SHIFT) + (abs_s >> ENV_SHIFT);

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        ts_d    = ts_q;
        peak_d  = peak_q;
        pk_ts_d = pk_ts_q;
        hcnt_d  = hcnt_q;
        push    = 1'b0;
        if (sample_valid) begin
            env_d = env_n;
            ts_d  = ts_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (env_n >= thr_on_q) begin
                        state_d = ATTACK;
                        peak_d  = abs_s;
                        pk_ts_d = ts_q;
                    end
                end
                ATTACK: begin
                    if (abs_s > peak_q) begin
                        peak_d  = abs_s;
                        pk_ts_d = ts_q;
                    end
                    if (env_n < thr_off_q) begin
                        push    = 1'b1;
                        hcnt_d  = holdoff_q;
                        state_d = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hcnt_q != '0) begin
                        hcnt_d = hcnt_q - 1'b1;
                    end else if (env_n < thr_on_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push_ev.ts   = 16'(pk_ts_d);
        push_ev.peak = peak_d[23:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            env_q   <= '0;
            ts_q    <= '0;
            peak_q  <= '0;
            pk_ts_q <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            ts_q    <= ts_d;
            peak_q  <= peak_d;
            pk_ts_q <= pk_ts_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_on_q  <= THR_ON_DEFAULT;
            thr_off_q <= THR_OFF_DEFAULT;
            holdoff_q <= HOLDOFF_DEFAULT;
        end else if (wr_en) begin
            case (address)
                REG_THR_ON:  thr_on_q  <= writedata[23:0];
                REG_THR_OFF: thr_off_q <= writedata[23:0];
                REG_HOLDOFF: holdoff_q <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // A dropped event outranks a same-cycle clear so the loss stays visible.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && (address == REG_STATUS)) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            REG_THR_ON:  rdata_d = {8'h00, thr_on_q};
            REG_THR_OFF: rdata_d = {8'h00, thr_off_q};
            REG_HOLDOFF: rdata_d = {16'h0000, holdoff_q};
            REG_STATUS:  rdata_d = {23'd0, overflow_q, 8'(fifo_count)};
            REG_EVENT:   rdata_d = fifo_empty ? '0 : fifo_dout;
            REG_ENV:     rdata_d = {8'h00, env_q};
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            readdata_q  <= '0;
            hit_pulse_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            hit_pulse_q <= push;
            if (rd_en) begin
                readdata_q <= rdata_d;
            end
        end
    end

    hit_event_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_ev),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign readdata  = readdata_q;
    assign hit_pulse = hit_pulse_q;

endmodule

// File: tb/tb_hit_detector.sv
// Bench for hit_detector: two instances (K=0 and K=3) share one bus and are
// checked every cycle against a behavioural model of strikes and the event queue.
module tb_hit_detector;

    localparam int DEPTH = 8;
    localparam int WAITING = 0, IN_STRIKE = 1, COOLING = 2;

    logic        clk = 1'b0;
    logic        reset, sample_valid, chipselect, read, write;
    logic [23:0] sample_in;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] rdata0, rdata1;
    logic        hp0, hp1;

    always #5 clk = ~clk;

    hit_detector #(.ENV_SHIFT(0), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(rdata0), .hit_pulse(hp0));

    hit_detector #(.ENV_SHIFT(3), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(rdata1), .hit_pulse(hp1));

    int n_checks = 0, n_pass = 0, n_fail = 0;

    int unsigned m_env[2], m_ts[2], m_peak[2], m_pkts[2], m_cool[2];
    int          m_mode[2];
    bit          m_ovf[2];
    logic [31:0] q0[$], q1[$];
    logic [23:0] m_thr_on, m_thr_off;
    logic [15:0] m_hold;
    logic [31:0] exp_rd[2];
    bit          exp_hp[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int kshift(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int unsigned abs24(input logic [23:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return v;
    endfunction

    function automatic int fifo_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] fifo_head(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void fifo_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void fifo_push(input int i, input logic [31:0] v);
        if (i == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic logic [31:0] reg_value(input int i, input logic [2:0] a);
        case (a)
            3'd0: return {8'h00, m_thr_on};
            3'd1: return {8'h00, m_thr_off};
            3'd2: return {16'h0000, m_hold};
            3'd3: return {23'd0, m_ovf[i], 8'(fifo_size(i))};
            3'd4: return (fifo_size(i) > 0) ? fifo_head(i) : 32'h0;
            3'd5: return 32'(m_env[i]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_sample(input int i, input logic [23:0] s, output bit pushed,
                                output logic [31:0] ev);
        int unsigned a, k, tnow;
        a    = abs24(s);
        k    = kshift(i);
        tnow = m_ts[i];
        m_env[i] = m_env[i] - (m_env[i] >> k) + (a >> k);
        m_ts[i]  = (m_ts[i] + 1) % 65536;
        pushed = 1'b0;
        ev     = '0;
        case (m_mode[i])
            WAITING: begin
                if (m_env[i] >= m_thr_on) begin
                    m_mode[i] = IN_STRIKE;
                    m_peak[i] = a;
                    m_pkts[i] = tnow;
                end
            end
            IN_STRIKE: begin
                if (a > m_peak[i]) begin
                    m_peak[i] = a;
                    m_pkts[i] = tnow;
                end
                if (m_env[i] < m_thr_off) begin
                    pushed    = 1'b1;
                    ev        = (m_pkts[i] << 16) | (m_peak[i] >> 8);
                    m_cool[i] = m_hold;
                    m_mode[i] = COOLING;
                end
            end
            default: begin
                if (m_cool[i] > 0) m_cool[i] = m_cool[i] - 1;
                else if (m_env[i] < m_thr_on) m_mode[i] = WAITING;
            end
        endcase
    endtask

    task automatic step(input bit v, input logic [23:0] s, input bit r, input bit w,
                        input logic [2:0] a, input logic [31:0] d);
        bit          pushed;
        logic [31:0] ev;
        sample_valid = v;
        sample_in    = s;
        chipselect   = r || w;
        read         = r;
        write        = w;
        address      = a;
        writedata    = d;
        for (int i = 0; i < 2; i++) begin
            if (r) exp_rd[i] = reg_value(i, a);
            pushed = 1'b0;
            ev     = '0;
            if (v) model_sample(i, s, pushed, ev);
            if (w && a == 3'd3) m_ovf[i] = 1'b0;
            if (r && a == 3'd4 && fifo_size(i) > 0) fifo_pop(i);
            if (pushed) begin
                if (fifo_size(i) < DEPTH) fifo_push(i, ev);
                else m_ovf[i] = 1'b1;
            end
            exp_hp[i] = pushed;
        end
        if (w) begin
            case (a)
                3'd0: m_thr_on  = d[23:0];
                3'd1: m_thr_off = d[23:0];
                3'd2: m_hold    = d[15:0];
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk("hit_pulse0", {31'd0, hp0}, {31'd0, exp_hp[0]});
        chk("hit_pulse1", {31'd0, hp1}, {31'd0, exp_hp[1]});
        chk("readdata0", rdata0, exp_rd[0]);
        chk("readdata1", rdata1, exp_rd[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0; sample_in = '0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        for (int i = 0; i < 2; i++) begin
            m_env[i] = 0; m_ts[i] = 0; m_peak[i] = 0; m_pkts[i] = 0; m_cool[i] = 0;
            m_mode[i] = WAITING; m_ovf[i] = 1'b0; exp_rd[i] = '0; exp_hp[i] = 1'b0;
        end
        q0.delete();
        q1.delete();
        m_thr_on = 24'h100000; m_thr_off = 24'h080000; m_hold = 16'd2400;
        #1;
        chk("rst_readdata0", rdata0, 32'h0);
        chk("rst_readdata1", rdata1, 32'h0);
        chk("rst_hit_pulse0", {31'd0, hp0}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, '0, 1'b1, 1'b0, a, '0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b0, '0, 1'b0, 1'b1, a, d);
    endtask

    task automatic smp(input logic [23:0] s);
        step(1'b1, s, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b0; sample_valid = 1'b0; sample_in = '0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        #2;
        do_reset();
        rd(3'd3); chk("rst_status", rdata0, 32'h0);
        rd(3'd0); chk("rst_thr_on", rdata0, 32'h00100000);
        rd(3'd1); chk("rst_thr_off", rdata0, 32'h00080000);
        rd(3'd2); chk("rst_holdoff", rdata0, 32'd2400);

        // Basic strike: one event at ts=2, peak 0x3000
        smp(24'h000000); smp(24'h120000); smp(24'h300000); smp(-24'sh200000);
        smp(24'h070000); chk("hit_at_ts4", {31'd0, hp0}, 32'h1);
        smp(24'h000000);
        rd(3'd3); chk("count_one", rdata0, 32'h1);
        rd(3'd4); chk("event_first", rdata0, 32'h00023000);
        rd(3'd3); chk("count_zero", rdata0, 32'h0);
        rd(3'd4); chk("event_empty", rdata0, 32'h0);

        // Saturation of the most-negative sample
        do_reset();
        smp(24'h800000);
        rd(3'd5); chk("env_saturated", rdata0, 32'h007FFFFF);
        smp(24'h000000); chk("sat_hit", {31'd0, hp0}, 32'h1);
        rd(3'd4); chk("sat_event", rdata0, 32'h00007FFF);

        // Reset in the middle of a strike drops it and restores defaults
        do_reset();
        smp(24'h800000);
        do_reset();
        rd(3'd5); chk("rst_env", rdata0, 32'h0);
        rd(3'd3); chk("rst_count", rdata0, 32'h0);
        rd(3'd0); chk("rst_thr_on2", rdata0, 32'h00100000);
        smp(24'h000000); chk("no_event_after_rst", {31'd0, hp0}, 32'h0);
        rd(3'd3); chk("rst_count2", rdata0, 32'h0);

        // Holdoff=3: strike 2 samples after push ignored, 5 after accepted
        do_reset();
        wr(3'd2, 32'd3);
        smp(24'h200000); smp(24'h000000);
        smp(24'h000000); smp(24'h200000); smp(24'h000000); smp(24'h000000);
        smp(24'h000000); smp(24'h000000);
        rd(3'd3); chk("holdoff_ignored", rdata0, 32'h1);
        smp(24'h200000); smp(24'h000000);
        for (int j = 0; j < 4; j++) smp(24'h000000);
        smp(24'h200000); smp(24'h000000);
        rd(3'd3); chk("holdoff_rearm", rdata0, 32'h3);

        // Overflow: 9 strikes into an 8-deep FIFO
        do_reset();
        wr(3'd2, 32'd0);
        for (int k = 0; k < 9; k++) begin
            smp(24'h200000); smp(24'h000000); smp(24'h000000);
        end
        rd(3'd3); chk("overflow_status", rdata0, 32'h00000108);
        for (int j = 0; j < 8; j++) begin
            rd(3'd4);
            if (j == 0) chk("ovf_oldest", rdata0, 32'h00002000);
            if (j == 7) chk("ovf_eighth", rdata0, 32'h00152000);
        end
        rd(3'd3); chk("ovf_drained", rdata0, 32'h00000100);
        wr(3'd3, 32'h0);
        rd(3'd3); chk("ovf_cleared", rdata0, 32'h0);

        // Full FIFO: push coinciding with a pop
        for (int k = 0; k < 8; k++) begin
            smp(24'h200000); smp(24'h000000); smp(24'h000000);
        end
        smp(24'h200000);
        step(1'b1, 24'h000000, 1'b1, 1'b0, 3'd4, '0);
        chk("full_pushpop_head", rdata0, 32'h001B2000);
        rd(3'd3); chk("full_pushpop_count", rdata0, 32'h00000008);

        // Randomised traffic
        do_reset();
        wr(3'd0, {8'hA5, 24'h0C0000});
        wr(3'd1, {8'h5A, 24'h060000});
        wr(3'd2, {16'hBEEF, 16'd4});
        for (int n = 0; n < 3000; n++) begin
            bit          v, r, w;
            logic [23:0] s, mag;
            logic [2:0]  a;
            logic [31:0] d;
            int          sel;
            v   = ($urandom % 3) != 0;
            sel = $urandom % 8;
            if (sel <= 3) mag = 24'($urandom_range(24'h7FFFFF, 24'h0C0000));
            else          mag = 24'($urandom_range(24'h050000, 0));
            s = ($urandom % 2 != 0) ? -mag : mag;
            if (sel == 0) s = 24'h800000;
            r = 1'b0; w = 1'b0; a = '0; d = '0;
            sel = $urandom % 16;
            if (sel < 5) begin
                r = 1'b1;
                a = ($urandom % 2 != 0) ? 3'd4 : 3'($urandom % 8);
            end else if (sel == 5) begin
                w = 1'b1;
                a = 3'($urandom % 8);
                d = $urandom;
                case (a)
                    3'd0: d[23:0] = 24'($urandom_range(24'h200000, 24'h080000));
                    3'd1: d[23:0] = 24'($urandom_range(24'h180000, 24'h020000));
                    3'd2: d[15:0] = 16'($urandom_range(6, 0));
                    default: ;
                endcase
            end
            step(v, s, r, w, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
